// File: rtl/iq_dispatch_if.sv
// Bundle between the instruction queue / dispatch stage, the instruction memory and the
// reservation stations. master = iq_dispatch, slave = memory + stations + redirect source.
interface iq_dispatch_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int PC_W   = 4,
    parameter int NUM_RS = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              flush;
    logic [PC_W-1:0]   redirect_pc;
    logic [NUM_RS-1:0] rs_free;
    logic              dispatch_valid;
    logic [NUM_RS-1:0] dispatch_rs;
    logic [DATA_W-1:0] dispatch_instr;
    logic [PC_W-1:0]   dispatch_pc;
    logic              illegal_op;
    logic [CNT_W-1:0]  iq_count;
    logic              iq_full;
    logic              iq_empty;

    modport master (
        output imem_req, imem_addr, dispatch_valid, dispatch_rs, dispatch_instr,
               dispatch_pc, illegal_op, iq_count, iq_full, iq_empty,
        input  imem_data, flush, redirect_pc, rs_free
    );

    modport slave (
        input  imem_req, imem_addr, dispatch_valid, dispatch_rs, dispatch_instr,
               dispatch_pc, illegal_op, iq_count, iq_full, iq_empty,
        output imem_data, flush, redirect_pc, rs_free
    );
endinterface

// File: rtl/iq_dispatch.sv
// Instruction queue + in-order dispatch for the Tomasulo front end.
// Optional IQ_BYPASS_EN: dispatch a returning instruction straight from imem_data when the queue is empty.
module iq_dispatch #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int PC_W   = 4,
    parameter int NUM_RS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    iq_dispatch_if.master bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CLS_W  = $clog2(NUM_RS);
    localparam int RS_PAD = 1 << CLS_W;
    localparam logic [CLS_W:0]   NUM_RS_L = (CLS_W + 1)'(NUM_RS);
    localparam logic [CNT_W-1:0] DEPTH_L  = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [PC_W-1:0]  pc, ret_pc, imem_addr_q;
    logic             imem_req_q, inflight, kill;

    entry_t            head_e, ret_e, disp_e;
    logic [CLS_W-1:0]  head_cls, disp_cls;
    logic [RS_PAD-1:0] rs_free_pad;
    logic              q_has, head_legal, ret_live;
    logic              pop_disp, pop_ill, pop, push, bypass, disp_valid;
    logic [CNT_W:0]    demand;
    logic              fetch_ok;

    assign head_e      = mem[head];
    assign ret_e       = '{instr: bus.imem_data, pc: ret_pc};
    assign rs_free_pad = RS_PAD'(bus.rs_free);
    assign head_cls    = head_e.instr[DATA_W-1 -: CLS_W];
    assign head_legal  = {1'b0, head_cls} < NUM_RS_L;
    assign q_has       = (count != '0);
    assign ret_live    = inflight & ~kill & ~bus.flush;

    // Flush suppresses every pop; a stalled head blocks all younger entries.
    assign pop_disp = ~bus.flush & q_has & head_legal & rs_free_pad[head_cls];
    assign pop_ill  = ~bus.flush & q_has & ~head_legal;
    assign pop      = pop_disp | pop_ill;

`ifdef IQ_BYPASS_EN
    logic [CLS_W-1:0] ret_cls;
    assign ret_cls = bus.imem_data[DATA_W-1 -: CLS_W];
    assign bypass  = ret_live & ~q_has & ({1'b0, ret_cls} < NUM_RS_L) & rs_free_pad[ret_cls];
`else
    assign bypass  = 1'b0;
`endif

    assign push       = ret_live & ~bypass;
    assign disp_valid = pop_disp | bypass;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        disp_e   = head_e;
        disp_cls = head_cls;
        if (bypass) begin
            disp_e   = ret_e;
            disp_cls = ret_e.instr[DATA_W-1 -: CLS_W];
        end
    end

    // Conservative room check: entries held + return arriving now + request outstanding.
    assign demand   = {1'b0, count} + {{CNT_W{1'b0}}, inflight & ~kill} + {{CNT_W{1'b0}}, imem_req_q};
    assign fetch_ok = demand < {1'b0, DEPTH_L};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            pc          <= '0;
            ret_pc      <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
        end else begin
            inflight <= imem_req_q;
            ret_pc   <= imem_addr_q;
            kill     <= bus.flush;
            if (bus.flush) begin
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                imem_req_q  <= 1'b1;
                imem_addr_q <= bus.redirect_pc;
                pc          <= bus.redirect_pc + 1'b1;
            end else begin
                imem_req_q <= fetch_ok;
                if (fetch_ok) begin
                    imem_addr_q <= pc;
                    pc          <= pc + 1'b1;
                end
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: queue storage is not reset; head, tail and count decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= ret_e;
    end

    assign bus.imem_req       = imem_req_q;
    assign bus.imem_addr      = imem_addr_q;
    assign bus.dispatch_valid = disp_valid;
    assign bus.dispatch_rs    = disp_valid ? (NUM_RS'(1) << disp_cls) : '0;
    assign bus.dispatch_instr = disp_valid ? disp_e.instr : '0;
    assign bus.dispatch_pc    = disp_valid ? disp_e.pc : '0;
    assign bus.illegal_op     = pop_ill;
    assign bus.iq_count       = count;
    assign bus.iq_full        = (count == DEPTH_L);
    assign bus.iq_empty       = ~q_has;
endmodule
